alu_share_arbiter: RTL and testbench

//   Shares one combinational 32-bit ALU (4-bit control-line opcode) between NREQ requesters.

---
 rtl/alu_share_if.sv | 26 ++
 rtl/alu_share_arbiter.sv | 110 +++++++++++
 tb/tb_alu_share_arbiter.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/alu_share_if.sv
// Requester/response handshake bundle for the shared-ALU arbiter.
// master = issuing side plus response consumer; slave = the arbiter.
interface alu_share_if #(
  parameter int NREQ = 2,
  parameter int IDW  = 1
);
  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ-1:0][3:0]  req_op;
  logic [NREQ-1:0][31:0] req_a;
  logic [NREQ-1:0][31:0] req_b;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [IDW-1:0]        rsp_id;
  logic [31:0]           rsp_result;
  logic                  rsp_err;

  modport master (
    output req_valid, req_op, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_result, rsp_err
  );
  modport slave (
    input  req_valid, req_op, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_result, rsp_err
  );
endinterface

// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter sharing one combinational ALU among NREQ requesters;
// registers the ALU result into a one-entry response buffer and keeps N/Z/V.
module alu_share_arbiter #(
  parameter int NREQ = 2,
  parameter int IDW  = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  alu_share_if.slave  bus,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [3:0]  alu_gin,
  input  logic [31:0] alu_sum,
  output logic        status_n,
  output logic        status_z,
  output logic        status_v
);
  localparam logic [3:0] OP_AND = 4'b0000, OP_OR  = 4'b0001, OP_ADD = 4'b0010,
                         OP_SUB = 4'b0110, OP_SLT = 4'b0111, OP_PSA = 4'b1000,
                         OP_XOR = 4'b1001, OP_NOR = 4'b1010;

  logic [IDW-1:0] ptr, gnt, rsp_id_q;
  logic           gnt_vld, can_accept, op_ok, v_nxt;
  logic           rsp_valid_q, rsp_err_q;
  logic [31:0]    rsp_result_q, a_q, b_q;
  logic [3:0]     gin_q;
  int             idx;

  assign can_accept = !rsp_valid_q || bus.rsp_ready;

  // Grant is gated by rst_n so every output reads 0 while reset is held.
  always_comb begin
    gnt_vld = 1'b0;
    gnt     = '0;
    idx     = 0;
    if (rst_n && can_accept) begin
      for (int k = 0; k < NREQ; k++) begin
        idx = int'(ptr) + k;
        if (idx >= NREQ) idx = idx - NREQ;
        if (!gnt_vld && bus.req_valid[idx]) begin
          gnt_vld = 1'b1;
          gnt     = IDW'(idx);
        end
      end
    end
  end

  for (genvar i = 0; i < NREQ; i++) begin : g_rdy
    assign bus.req_ready[i] = gnt_vld && (int'(gnt) == i);
  end

  // Ungranted cycles replay the last issued operands so the ALU input is quiet.
  assign alu_a   = gnt_vld ? bus.req_a[gnt]  : a_q;
  assign alu_b   = gnt_vld ? bus.req_b[gnt]  : b_q;
  assign alu_gin = gnt_vld ? bus.req_op[gnt] : gin_q;

  always_comb begin
    op_ok = 1'b0;
    v_nxt = 1'b0;
    case (alu_gin)
      OP_AND, OP_OR, OP_SLT, OP_PSA, OP_XOR, OP_NOR: op_ok = 1'b1;
      OP_ADD: begin
        op_ok = 1'b1;
        v_nxt = (alu_a[31] & alu_b[31] & ~alu_sum[31]) | (~alu_a[31] & ~alu_b[31] & alu_sum[31]);
      end
      OP_SUB: begin
        op_ok = 1'b1;
        v_nxt = (alu_a[31] & ~alu_b[31] & ~alu_sum[31]) | (~alu_a[31] & alu_b[31] & alu_sum[31]);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr          <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= '0;
      rsp_result_q <= '0;
      rsp_err_q    <= 1'b0;
      a_q          <= '0;
      b_q          <= '0;
      gin_q        <= '0;
      status_n     <= 1'b0;
      status_z     <= 1'b0;
      status_v     <= 1'b0;
    end else if (gnt_vld) begin
      rsp_valid_q  <= 1'b1;
      rsp_id_q     <= gnt;
      rsp_result_q <= op_ok ? alu_sum : 32'd0;
      rsp_err_q    <= !op_ok;
      ptr          <= (int'(gnt) == NREQ - 1) ? '0 : gnt + 1'b1;
      a_q          <= alu_a;
      b_q          <= alu_b;
      gin_q        <= alu_gin;
      if (op_ok) begin
        status_n <= alu_sum[31];
        status_z <= (alu_sum == 32'd0);
        status_v <= v_nxt;
      end
    end else if (rsp_valid_q && bus.rsp_ready) begin
      rsp_valid_q <= 1'b0;
    end
  end

  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_id     = rsp_id_q;
  assign bus.rsp_result = rsp_result_q;
  assign bus.rsp_err    = rsp_err_q;
endmodule

// File: tb/tb_alu_share_arbiter.sv
// Bench for alu_share_arbiter: transaction-level model checked every cycle
// plus directed scenarios with literal expected values.
module tb_alu_share_arbiter;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] alu_a, alu_b, alu_sum;
  logic [3:0]  alu_gin;
  logic        status_n, status_z, status_v;
  int          tests = 0, fails = 0;

  alu_share_if #(.NREQ(2), .IDW(1)) bus ();

  alu_share_arbiter #(.NREQ(2), .IDW(1)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus),
    .alu_a(alu_a), .alu_b(alu_b), .alu_gin(alu_gin), .alu_sum(alu_sum),
    .status_n(status_n), .status_z(status_z), .status_v(status_v)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] alu_f(logic [3:0] op, logic [31:0] a, logic [31:0] b);
    case (op)
      4'b0010: return a + b;
      4'b0110: return a - b;
      4'b0111: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'b0000: return a & b;
      4'b0001: return a | b;
      4'b1010: return ~(a | b);
      4'b1001: return a ^ b;
      4'b1000: return a;
      default: return a ^ b ^ 32'hDEAD_BEEF;
    endcase
  endfunction

  always_comb alu_sum = alu_f(alu_gin, alu_a, alu_b);

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int          m_ptr, m_id, p_ptr, p_id, g;
  bit          m_valid, m_err, m_n, m_z, m_v, p_valid, p_err, p_n, p_z, p_v, ok;
  logic [31:0] m_res, m_la, m_lb, p_res, p_la, p_lb, ea, eb;
  logic [3:0]  m_lg, p_lg, eo;
  longint      wide;

  task automatic model_reset();
    m_ptr = 0; m_id = 0; m_valid = 0; m_err = 0; m_res = 0;
    m_n = 0; m_z = 0; m_v = 0; m_la = 0; m_lb = 0; m_lg = 0;
  endtask

  function automatic bit legal(logic [3:0] op);
    return op inside {4'b0010, 4'b0110, 4'b0111, 4'b0000, 4'b0001, 4'b1010, 4'b1001, 4'b1000};
  endfunction

  always begin
    @(negedge clk);
    if (!rst_n) begin
      model_reset();
      chk("rst_outs_zero", 64'(|{bus.req_ready, bus.rsp_valid, bus.rsp_id, bus.rsp_result, bus.rsp_err,
                                 status_n, status_z, status_v, alu_a, alu_b, alu_gin}), 64'd0);
    end else begin
      g = -1;
      if (!m_valid || bus.rsp_ready)
        for (int k = 0; k < 2; k++)
          if (g < 0 && bus.req_valid[(m_ptr + k) % 2]) g = (m_ptr + k) % 2;
      chk("req_ready", 64'(bus.req_ready), (g < 0) ? 64'd0 : 64'(1 << g));
      chk("rsp_valid", 64'(bus.rsp_valid), 64'(m_valid));
      if (m_valid) begin
        chk("rsp_id", 64'(bus.rsp_id), 64'(m_id));
        chk("rsp_result", 64'(bus.rsp_result), 64'(m_res));
        chk("rsp_err", 64'(bus.rsp_err), 64'(m_err));
      end
      chk("flags", 64'({status_n, status_z, status_v}), 64'({m_n, m_z, m_v}));
      ea = (g < 0) ? m_la : bus.req_a[g];
      eb = (g < 0) ? m_lb : bus.req_b[g];
      eo = (g < 0) ? m_lg : bus.req_op[g];
      chk("alu_drive", {28'd0, alu_gin, alu_a}, {28'd0, eo, ea});
      chk("alu_b", 64'(alu_b), 64'(eb));
      p_valid = m_valid; p_id = m_id; p_res = m_res; p_err = m_err; p_ptr = m_ptr;
      p_n = m_n; p_z = m_z; p_v = m_v; p_la = m_la; p_lb = m_lb; p_lg = m_lg;
      if (g >= 0) begin
        ok = legal(eo);
        p_valid = 1; p_id = g; p_ptr = (g + 1) % 2; p_err = !ok;
        p_res = ok ? alu_f(eo, ea, eb) : 32'd0;
        p_la = ea; p_lb = eb; p_lg = eo;
        if (ok) begin
          p_z = (p_res == 0);
          p_n = p_res[31];
          // overflow = true signed result does not fit in 32 bits
          wide = (eo == 4'b0010) ? longint'($signed(ea)) + longint'($signed(eb))
                                 : longint'($signed(ea)) - longint'($signed(eb));
          p_v = (eo inside {4'b0010, 4'b0110}) && (wide > 64'sd2147483647 || wide < -64'sd2147483648);
        end
      end else if (m_valid && bus.rsp_ready) p_valid = 0;
      @(posedge clk);
      if (rst_n) begin
        m_valid = p_valid; m_id = p_id; m_res = p_res; m_err = p_err; m_ptr = p_ptr;
        m_n = p_n; m_z = p_z; m_v = p_v; m_la = p_la; m_lb = p_lb; m_lg = p_lg;
      end else model_reset();
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic drv(int i, logic v, logic [3:0] op, logic [31:0] a, logic [31:0] b);
    bus.req_valid[i] = v; bus.req_op[i] = op; bus.req_a[i] = a; bus.req_b[i] = b;
  endtask

  typedef struct { logic [3:0] op; logic [31:0] a, b; } vec_t;
  vec_t vecs[7] = '{
    '{4'b0111, 32'hFFFF_FFFF, 32'd1},   // SLT -1 < 1
    '{4'b0000, 32'hF0F0_F0F0, 32'hFF00_FF00},
    '{4'b0001, 32'h0000_0F00, 32'h0000_00F0},
    '{4'b1010, 32'h0000_0000, 32'h0000_0000},
    '{4'b1001, 32'hAAAA_AAAA, 32'h5555_5555},
    '{4'b1000, 32'h1234_5678, 32'hFFFF_FFFF},
    '{4'b0110, 32'h8000_0000, 32'd1}    // SUB overflow
  };
  logic [1:0] seq [6];

  initial begin
    bus.req_valid = '0; bus.req_op = '0; bus.req_a = '0; bus.req_b = '0; bus.rsp_ready = 1'b1;
    #3;
    chk("reset_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    chk("reset_flags", 64'({status_n, status_z, status_v}), 64'd0);
    repeat (2) step();
    rst_n = 1'b1;

    // single op
    drv(0, 1, 4'b0010, 32'd7, 32'd5);
    @(negedge clk); chk("single_ready", 64'(bus.req_ready), 64'd1);
    step(); drv(0, 0, 4'b0010, 0, 0);
    chk("single_rsp", {bus.rsp_valid, 7'd0, 7'd0, bus.rsp_id, bus.rsp_result}, {1'b1, 14'd0, 1'b0, 32'd12});
    chk("single_flags", 64'({status_n, status_z, status_v}), 64'd0);

    // overflow then zero
    drv(1, 1, 4'b0010, 32'h7FFF_FFFF, 32'd1);
    step(); drv(1, 1, 4'b0110, 32'd5, 32'd5);
    chk("ovf_result", 64'(bus.rsp_result), 64'h8000_0000);
    chk("ovf_flags", 64'({status_n, status_z, status_v}), 64'b101);
    step(); drv(1, 0, 4'b0, 0, 0);
    chk("sub_zero", {bus.rsp_result, 29'd0, status_n, status_z, status_v}, {32'd0, 29'd0, 3'b010});

    // fairness
    drv(0, 1, 4'b0010, 32'd1, 32'd2); drv(1, 1, 4'b0010, 32'd10, 32'd20);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk); seq[i] = bus.req_ready;
      step();
    end
    for (int i = 0; i < 6; i++) chk($sformatf("fair_%0d", i), 64'(seq[i]), (i % 2) ? 64'd2 : 64'd1);

    // backpressure
    drv(1, 0, 4'b0, 0, 0); drv(0, 1, 4'b0001, 32'h8000_0000, 32'd1); bus.rsp_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_ready", 64'(bus.req_ready), 64'd0);
      chk("bp_hold", {bus.rsp_valid, 30'd0, bus.rsp_id, bus.rsp_result}, {1'b1, 30'd0, 1'b1, 32'd30});
      step();
    end
    bus.rsp_ready = 1'b1;
    @(negedge clk); chk("bp_release_ready", 64'(bus.req_ready), 64'd1);
    step(); drv(0, 1, 4'b1111, 32'd3, 32'd4);
    chk("bp_rsp", 64'(bus.rsp_result), 64'h8000_0001);
    chk("bp_flags", 64'({status_n, status_z, status_v}), 64'b100);

    // illegal opcode
    step(); drv(0, 0, 4'b0, 0, 0);
    chk("bad_rsp", {bus.rsp_err, 31'd0, bus.rsp_result}, {1'b1, 31'd0, 32'd0});
    chk("bad_flags_hold", 64'({status_n, status_z, status_v}), 64'b100);

    // op sweep on requester 1
    for (int i = 0; i < 7; i++) begin
      drv(1, 1, vecs[i].op, vecs[i].a, vecs[i].b);
      step();
      if (i == 0) chk("slt_rsp", {bus.rsp_result, 29'd0, status_n, status_z, status_v}, {32'd1, 32'd0});
    end
    drv(1, 0, 4'b0, 0, 0);
    chk("sub_ovf", {bus.rsp_result, 29'd0, status_n, status_z, status_v}, {32'h7FFF_FFFF, 29'd0, 3'b001});

    // reset mid-burst
    drv(0, 1, 4'b0010, 32'd100, 32'd1); drv(1, 1, 4'b0110, 32'd9, 32'd3);
    repeat (3) step();
    @(negedge clk); #2 rst_n = 1'b0;
    #1;
    chk("midrst_zero", 64'(|{bus.req_ready, bus.rsp_valid, bus.rsp_result, bus.rsp_id, bus.rsp_err,
                             status_n, status_z, status_v, alu_a, alu_b, alu_gin}), 64'd0);
    repeat (2) step();
    rst_n = 1'b1;
    @(negedge clk); chk("post_rst_grant", 64'(bus.req_ready), 64'd1);
    step();
    chk("post_rst_rsp", {bus.rsp_valid, 30'd0, bus.rsp_id, bus.rsp_result}, {1'b1, 31'd0, 32'd101});
    drv(0, 0, 4'b0, 0, 0); drv(1, 0, 4'b0, 0, 0);
    repeat (3) step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
